// File: rtl/fifo_rr_arbiter_pkg.sv
// Shared definitions for the lane read scheduler: state encodings and lane geometry.
package fsm_defs;
  localparam int NUM_LANES = 4;
  localparam int LANE_W    = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARB   = 2'd1,
    GRANT = 2'd2
  } state_t;

  function automatic logic [NUM_LANES-1:0] lane_onehot(input logic [LANE_W-1:0] idx);
    logic [NUM_LANES-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction
endpackage

// File: rtl/fifo_rr_arbiter_rr_pick4.sv
// Combinational round-robin picker: first eligible lane starting at ptr, wrapping mod 4.
module rr_pick4
  import fsm_defs::*;
(
  input  logic [NUM_LANES-1:0] elig,
  input  logic [LANE_W-1:0]    ptr,
  output logic                 found,
  output logic [LANE_W-1:0]    idx
);

  logic [2*NUM_LANES-1:0] w_dbl;
  logic [NUM_LANES-1:0]   w_rot;

  // Rotate so that bit 0 is the lane at ptr; lowest set bit is the winner.
  assign w_dbl = {elig, elig} >> ptr;
  assign w_rot = w_dbl[NUM_LANES-1:0];

  always_comb begin
    found = 1'b0;
    idx   = ptr;
    for (int k = NUM_LANES - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        found = 1'b1;
        idx   = ptr + LANE_W'(k);
      end
    end
  end

endmodule

// File: rtl/fifo_rr_arbiter.sv
// Round-robin burst scheduler merging four lane FIFOs onto one downstream stream.
module fifo_rr_arbiter
  import fsm_defs::*;
#(
  parameter int DATA_W    = 8,
  parameter int BURST_LEN = 4
) (
  input  logic                        CLK,
  input  logic                        sReset,
  input  logic                        sEnable,
  input  logic [NUM_LANES-1:0]        sEmpty,
  input  logic                        sDownFull,
  input  logic [NUM_LANES-1:0]        stbPause,
  input  logic [NUM_LANES-1:0]        stbContinue,
  input  logic [NUM_LANES*DATA_W-1:0] iData,
  output logic [NUM_LANES-1:0]        oPop,
  output logic                        oValid,
  output logic [DATA_W-1:0]           oData,
  output logic [LANE_W-1:0]           oLane,
  output logic [NUM_LANES-1:0]        oGrant,
  output logic [1:0]                  State
);

  localparam int              CNT_W    = $clog2(BURST_LEN) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_LEN - 1);

  state_t               r_state, w_state_nxt;
  logic [LANE_W-1:0]    r_ptr, w_ptr_nxt;
  logic [LANE_W-1:0]    r_g, w_g_nxt;
  logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
  logic [NUM_LANES-1:0] r_paused;
  logic [NUM_LANES-1:0] w_elig;
  logic [NUM_LANES-1:0] w_pop;
  logic [NUM_LANES-1:0] w_grant;
  logic                 w_found;
  logic [LANE_W-1:0]    w_pick;
  logic                 r_vld_p1;
  logic [LANE_W-1:0]    r_lane_p1;

  assign w_elig = ~sEmpty & ~r_paused;

  rr_pick4 u_pick (
    .elig  (w_elig),
    .ptr   (r_ptr),
    .found (w_found),
    .idx   (w_pick)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_g_nxt     = r_g;
    w_cnt_nxt   = r_cnt;
    w_pop       = '0;
    w_grant     = '0;
    unique case (r_state)
      IDLE: begin
        if (sEnable) w_state_nxt = ARB;
      end
      ARB: begin
        if (!sEnable) begin
          w_state_nxt = IDLE;
        end else if (w_found && !sDownFull) begin
          w_g_nxt     = w_pick;
          w_cnt_nxt   = '0;
          w_state_nxt = GRANT;
        end
      end
      GRANT: begin
        w_grant = lane_onehot(r_g);
        if (!sEnable) begin
          w_state_nxt = IDLE;
          w_ptr_nxt   = r_g + LANE_W'(1);
        end else if (!w_elig[r_g]) begin
          w_state_nxt = ARB;
          w_ptr_nxt   = r_g + LANE_W'(1);
        end else if (!sDownFull) begin
          // Full-flag stall simply skips this branch, holding the count.
          w_pop     = lane_onehot(r_g);
          w_cnt_nxt = r_cnt + CNT_W'(1);
          if (r_cnt == CNT_LAST) begin
            w_state_nxt = ARB;
            w_ptr_nxt   = r_g + LANE_W'(1);
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Reset suppresses the pop so no FIFO word is consumed and then lost.
  assign oPop   = w_pop & {NUM_LANES{~sReset}};
  assign oGrant = w_grant;
  assign State  = r_state;

  always_ff @(posedge CLK) begin
    if (sReset) begin
      r_state  <= IDLE;
      r_ptr    <= '0;
      r_g      <= '0;
      r_cnt    <= '0;
      r_paused <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_ptr    <= w_ptr_nxt;
      r_g      <= w_g_nxt;
      r_cnt    <= w_cnt_nxt;
      r_paused <= (r_paused & ~stbContinue) | stbPause;
    end
  end

  // Stage p1: remember which lane was popped while its FIFO produces the word.
  always_ff @(posedge CLK) begin
    if (sReset) begin
      r_vld_p1  <= 1'b0;
      r_lane_p1 <= '0;
    end else begin
      r_vld_p1  <= |w_pop;
      r_lane_p1 <= r_g;
    end
  end

  // Stage p2: capture the lane's read data onto the merged output.
  always_ff @(posedge CLK) begin
    if (sReset) begin
      oValid <= 1'b0;
      oData  <= '0;
      oLane  <= '0;
    end else begin
      oValid <= r_vld_p1;
      if (r_vld_p1) begin
        oData <= iData[int'(r_lane_p1)*DATA_W +: DATA_W];
        oLane <= r_lane_p1;
      end
    end
  end

endmodule
